// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM peripheral's SPI front end.
package pwm_pkg;

  localparam int unsigned SPI_BYTE_W   = 8;
  localparam int unsigned SPI_BITCNT_W = 3;

  // Levels the input synchronisers take in reset (bus idle).
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_N_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

  typedef enum logic {
    StIdle,
    StShift
  } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage input synchroniser with a history flop giving single-clk rise/fall pulses.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q   <= RESET_VAL;
    end else begin
      stages_q <= {stages_q[SYNC_STAGES-2:0], din};
      hist_q   <= stages_q[SYNC_STAGES-1];
    end
  end

  assign q    = stages_q[SYNC_STAGES-1];
  assign rise = q & ~hist_q;
  assign fall = ~q & hist_q;

endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 slave, MSB first, oversampled in the system clock domain.
// Delivers received bytes with a byte_sync pulse and shifts data_out back on miso.
module spi_bridge
  import pwm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  byte_sync,
  output logic [SPI_BYTE_W-1:0] data_in,
  input  logic [SPI_BYTE_W-1:0] data_out
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_n_s, cs_fall, cs_rise_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .q    (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CS_N_IDLE)) u_sync_cs_n (
    .clk  (clk),
    .rst  (rst),
    .din  (cs_n),
    .q    (cs_n_s),
    .rise (cs_rise_unused),
    .fall (cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(MOSI_IDLE)) u_sync_mosi (
    .clk  (clk),
    .rst  (rst),
    .din  (mosi),
    .q    (mosi_s),
    .rise (mosi_rise_unused),
    .fall (mosi_fall_unused)
  );

  spi_state_e state_q, state_d;
  logic       in_frame;

  logic [SPI_BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-1:0]   rx_shift_q, rx_shift_d;
  logic [SPI_BYTE_W-1:0]   tx_shift_q, tx_shift_d;
  logic [SPI_BYTE_W-1:0]   data_in_q, data_in_d;
  logic                    byte_sync_q, byte_sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cs_fall) state_d = StShift;
      StShift: if (cs_n_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_frame = (state_q == StShift);
    miso     = in_frame ? tx_shift_q[SPI_BYTE_W-1] : 1'b0;
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    data_in_d   = data_in_q;
    byte_sync_d = 1'b0;

    // Reload one clk after byte_sync so the decoder has settled data_out.
    if (cs_fall) begin
      bit_cnt_d  = '0;
      tx_shift_d = data_out;
    end else if (byte_sync_q) begin
      tx_shift_d = data_out;
    end else if (in_frame && sclk_fall && (bit_cnt_q != '0)) begin
      tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
    end

    if (in_frame && sclk_rise) begin
      rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
      bit_cnt_d  = bit_cnt_q + 1'b1;
      if (bit_cnt_q == '1) begin
        data_in_d   = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
        byte_sync_d = 1'b1;
      end
    end

    // Deselect drops any partial byte; a byte completing this same clk still goes out.
    if (cs_n_s) begin
      bit_cnt_d  = '0;
      rx_shift_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      data_in_q   <= '0;
      byte_sync_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      data_in_q   <= data_in_d;
      byte_sync_q <= byte_sync_d;
    end
  end

  assign byte_sync = byte_sync_q;
  assign data_in   = data_in_q;

endmodule
